act_unit_rr_scheduler: RTL and testbench
========================================

Name: act_unit_rr_scheduler

Overview:
- Shares one sequential activation unit (e.g. hardtanh_seq, fixed pipeline latency) among NUM_REQ requesters.
- Round-robin arbitration on the request side; a tag pipeline tracks which requester owns each in-flight sample; results are routed back as a one-hot valid plus a shared data bus.
- Sits between the PE/accumulator outputs and the single activation instance in the activation stage.

Parameters:
- DATA_WIDTH, 8, sample width, 2's complement, passed through untouched.
- NUM_REQ, 4, number of requesters, >=2.
- UNIT_LATENCY, 1, cycles from unit i_valid to unit o_valid, >=1.
- REQ_IDX_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- i_en  in  1  global enable; low freezes the scheduler and the unit.
- i_req_valid  in  NUM_REQ  per-requester sample valid.
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready.
- o_act_valid  out  1  to unit i_valid.
- o_act_data  out  DATA_WIDTH  to unit i_data_bus.
- o_act_en  out  1  to unit i_en.
- i_act_valid  in  1  from unit o_valid.
- i_act_data  in  DATA_WIDTH  from unit o_data_bus.
- o_rsp_valid  out  NUM_REQ  one-hot: result belongs to requester k.
- o_rsp_data  out  DATA_WIDTH  result data, shared bus.
- o_busy  out  1  high while any sample is in flight.
- o_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst_n=0): o_act_valid=0, o_act_data=0, o_rsp_valid=0, o_rsp_data=0, o_err=0, all tag stages invalid, RR pointer=0. o_act_en follows i_en combinationally. o_req_ready is 0 while rst_n=0.
- Arbitration (combinational, per cycle with i_en=1):
  - Search i_req_valid starting at index ptr and wrapping upward.
  - The first set bit k is granted: o_req_ready = one-hot(k).
  - No valid requests: o_req_ready=0.
  - o_req_ready may depend on i_req_valid; requesters must not make valid depend on ready.
- Pointer: on a grant of k, ptr <= (k+1) mod NUM_REQ at the clock edge. With no grant, ptr holds.
- Launch register: at the edge after a grant, o_act_valid<=1 and o_act_data<=granted data. With no grant, o_act_valid<=0 and o_act_data holds.
- Tag pipeline:
  - UNIT_LATENCY stages of {valid, REQ_IDX_W tag}.
  - Stage 0 loads {o_act_valid, launched tag}; each stage shifts one per enabled cycle.
  - The last stage aligns with i_act_valid.
- Response register:
  - When i_act_valid=1 and the last tag stage is valid: o_rsp_valid <= one-hot(tag), o_rsp_data <= i_act_data.
  - Otherwise o_rsp_valid<=0 and o_rsp_data holds.
- Latency: handshake in cycle t gives o_rsp_valid high in cycle t+UNIT_LATENCY+2 (3 for defaults). Throughput is one sample per cycle, with no bubbles under contention.
- o_busy: OR of o_act_valid, all tag-stage valids and o_rsp_valid.
- o_err: set and held until reset when i_act_valid disagrees with the last tag-stage valid (unit latency mismatch). A sample flagged this way is dropped (o_rsp_valid=0).
- i_en=0: o_req_ready=0. The launch register, tag pipeline, response register and ptr all hold; o_act_en=0 so the unit holds too. Resuming continues with no loss or duplication.
- All NUM_REQ valid continuously: strict rotation 0,1,2,3,0,...
- Single requester valid continuously: it is granted every cycle.
- Pointer wrap: a grant to NUM_REQ-1 sets ptr to 0.
- Reset mid-operation: in-flight samples are discarded; no o_rsp_valid is produced for them after reset release.
- Responses have no backpressure; the consumer must accept o_rsp_valid whenever it is asserted.

Test Plan:
- Bench setup: stub unit is a 1-cycle identity register honouring i_en; bench also runs with hardtanh_seq.
- Reset check: assert rst_n=0 mid-stream with 3 samples in flight -> all outputs 0 immediately; no o_rsp_valid after release; o_err=0.
- Single request: req1 data 8'h5A at cycle t -> o_req_ready=4'b0010 at t; o_act_valid at t+1 with 8'h5A; o_rsp_valid=4'b0010 with o_rsp_data=8'h5A at t+3.
- Full contention: all 4 valid for 8 cycles, data = 8'h10*k+n -> grants 0,1,2,3,0,1,2,3; responses arrive in the same order, each with correct data and tag; o_busy low 3 cycles after the last grant.
- Enable stall: deassert i_en for 4 cycles while 2 samples are in flight -> o_req_ready=0 and outputs frozen; after re-enable both responses appear once, in order, with correct tags.
- Pointer fairness and wrap: only req3 and req0 valid -> alternating grants 3,0,3,0; ptr wraps 3->0 correctly.
- Latency mismatch: bench stub with a 2-cycle delay -> o_err rises on the first misaligned i_act_valid and stays high until rst_n=0.

Source files
------------

// File: rtl/act_unit_rr_scheduler.sv
// act_unit_rr_scheduler: round-robin sharing of one fixed-latency activation unit among NUM_REQ requesters
module act_unit_rr_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int UNIT_LATENCY = 1,
  parameter int REQ_IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_act_valid,
  output logic [DATA_WIDTH-1:0]         o_act_data,
  output logic                          o_act_en,
  input  logic                          i_act_valid,
  input  logic [DATA_WIDTH-1:0]         i_act_data,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_busy,
  output logic                          o_err
);
  logic [REQ_IDX_W-1:0]    ptr, gidx, cand, act_tag;
  logic                    found, grant, hit;
  logic [UNIT_LATENCY-1:0] tag_v;
  logic [REQ_IDX_W-1:0]    tag_q [UNIT_LATENCY];
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = REQ_IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end
  assign grant       = found & i_en & rst_n;
  assign o_req_ready = grant ? NUM_REQ'(1) << gidx : '0;
  assign o_act_en    = i_en;
  // The last tag stage lines up with the unit's output valid; anything else is a latency mismatch.
  assign hit         = i_act_valid & tag_v[UNIT_LATENCY-1];
  assign o_busy      = o_act_valid | (|tag_v) | (|o_rsp_valid);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      act_tag     <= '0;
      o_act_valid <= 1'b0;
      o_act_data  <= '0;
      tag_v       <= '0;
      for (int i = 0; i < UNIT_LATENCY; i++) tag_q[i] <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_err       <= 1'b0;
    end else if (i_en) begin
      o_act_valid <= grant;
      if (grant) begin
        o_act_data <= i_req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
        act_tag    <= gidx;
        ptr        <= (gidx == REQ_IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      end
      tag_v[0] <= o_act_valid;
      tag_q[0] <= act_tag;
      for (int i = 1; i < UNIT_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      o_rsp_valid <= hit ? NUM_REQ'(1) << tag_q[UNIT_LATENCY-1] : '0;
      if (hit) o_rsp_data <= i_act_data;
      if (i_act_valid != tag_v[UNIT_LATENCY-1]) o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_act_unit_rr_scheduler.sv
// tb_act_unit_rr_scheduler: directed table plus hand sequences for stall, reset and latency mismatch
module tb_act_unit_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, en, sel2;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [31:0] req_data;
  logic        act_valid, act_en, unit_valid, busy, err;
  logic [7:0]  act_data, unit_data, rsp_data;
  logic        s1v, s2v;
  logic [7:0]  s1d, s2d;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [7:0]  rd;
    logic        busy;
  } vec_t;
  vec_t tbl [25];

  always #5 clk = ~clk;

  act_unit_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_act_valid(act_valid), .o_act_data(act_data), .o_act_en(act_en),
    .i_act_valid(unit_valid), .i_act_data(unit_data), .o_rsp_valid(rsp_valid),
    .o_rsp_data(rsp_data), .o_busy(busy), .o_err(err)
  );

  // Identity stub unit: 1-cycle output normally, 2-cycle output when sel2 is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1v <= 1'b0; s2v <= 1'b0; s1d <= '0; s2d <= '0;
    end else if (act_en) begin
      s1v <= act_valid; s1d <= act_data; s2v <= s1v; s2d <= s1d;
    end
  end
  assign unit_valid = sel2 ? s2v : s1v;
  assign unit_data  = sel2 ? s2d : s1d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] v, input logic [31:0] d);
    @(posedge clk); #1;
    en = e; req_valid = v; req_data = d;
  endtask

  initial begin
    tbl[0]  = '{4'hF, 32'h30201000, 4'h1, 4'h0, 8'h00, 1'b0};
    tbl[1]  = '{4'hF, 32'h31211101, 4'h2, 4'h0, 8'h00, 1'b1};
    tbl[2]  = '{4'hF, 32'h32221202, 4'h4, 4'h0, 8'h00, 1'b1};
    tbl[3]  = '{4'hF, 32'h33231303, 4'h8, 4'h1, 8'h00, 1'b1};
    tbl[4]  = '{4'hF, 32'h34241404, 4'h1, 4'h2, 8'h11, 1'b1};
    tbl[5]  = '{4'hF, 32'h35251505, 4'h2, 4'h4, 8'h22, 1'b1};
    tbl[6]  = '{4'hF, 32'h36261606, 4'h4, 4'h8, 8'h33, 1'b1};
    tbl[7]  = '{4'hF, 32'h37271707, 4'h8, 4'h1, 8'h04, 1'b1};
    tbl[8]  = '{4'h0, 32'h0,        4'h0, 4'h2, 8'h15, 1'b1};
    tbl[9]  = '{4'h0, 32'h0,        4'h0, 4'h4, 8'h26, 1'b1};
    tbl[10] = '{4'h0, 32'h0,        4'h0, 4'h8, 8'h37, 1'b1};
    tbl[11] = '{4'h0, 32'h0,        4'h0, 4'h0, 8'h37, 1'b0};
    tbl[12] = '{4'h2, 32'h00005A00, 4'h2, 4'h0, 8'h37, 1'b0};
    tbl[13] = '{4'h0, 32'h0,        4'h0, 4'h0, 8'h37, 1'b1};
    tbl[14] = '{4'h0, 32'h0,        4'h0, 4'h0, 8'h37, 1'b1};
    tbl[15] = '{4'h0, 32'h0,        4'h0, 4'h2, 8'h5A, 1'b1};
    tbl[16] = '{4'h0, 32'h0,        4'h0, 4'h0, 8'h5A, 1'b0};
    tbl[17] = '{4'h9, 32'hA30000A0, 4'h8, 4'h0, 8'h5A, 1'b0};
    tbl[18] = '{4'h9, 32'hB30000B0, 4'h1, 4'h0, 8'h5A, 1'b1};
    tbl[19] = '{4'h9, 32'hC30000C0, 4'h8, 4'h0, 8'h5A, 1'b1};
    tbl[20] = '{4'h9, 32'hD30000D0, 4'h1, 4'h8, 8'hA3, 1'b1};
    tbl[21] = '{4'h0, 32'h0,        4'h0, 4'h1, 8'hB0, 1'b1};
    tbl[22] = '{4'h0, 32'h0,        4'h0, 4'h8, 8'hC3, 1'b1};
    tbl[23] = '{4'h0, 32'h0,        4'h0, 4'h1, 8'hD0, 1'b1};
    tbl[24] = '{4'h0, 32'h0,        4'h0, 4'h0, 8'hD0, 1'b0};

    rst_n = 1'b0; en = 1'b1; sel2 = 1'b0; req_valid = '0; req_data = '0;
    #1;
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_act_valid", 32'(act_valid), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_act_en", 32'(act_en), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 25; r++) begin
      drive(1'b1, tbl[r].v, tbl[r].d);
      if (r == 13) chk("single_act_data", 32'(act_data), 32'h5A);
      @(negedge clk);
      chk($sformatf("ready_r%0d", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("rsp_valid_r%0d", r), 32'(rsp_valid), 32'(tbl[r].rv));
      chk($sformatf("rsp_data_r%0d", r), 32'(rsp_data), 32'(tbl[r].rd));
      chk($sformatf("busy_r%0d", r), 32'(busy), 32'(tbl[r].busy));
      chk($sformatf("err_r%0d", r), 32'(err), 0);
    end

    // Enable stall with two samples in flight (ptr is 1 here).
    drive(1'b1, 4'h3, 32'h0000E1E0);
    @(negedge clk) chk("stall_g0", 32'(req_ready), 32'h2);
    drive(1'b1, 4'h3, 32'h0000E1E0);
    @(negedge clk) chk("stall_g1", 32'(req_ready), 32'h1);
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 4'h3, 32'h0000E1E0);
      @(negedge clk);
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_act_en", 32'(act_en), 0);
      chk("stall_act_valid", 32'(act_valid), 1);
      chk("stall_act_data", 32'(act_data), 32'hE0);
      chk("stall_rsp_valid", 32'(rsp_valid), 0);
    end
    drive(1'b1, 4'h0, 32'h0);
    @(negedge clk) chk("resume_rsp0", 32'(rsp_valid), 0);
    drive(1'b1, 4'h0, 32'h0);
    @(negedge clk);
    chk("resume_rsp1_v", 32'(rsp_valid), 32'h2);
    chk("resume_rsp1_d", 32'(rsp_data), 32'hE1);
    drive(1'b1, 4'h0, 32'h0);
    @(negedge clk);
    chk("resume_rsp2_v", 32'(rsp_valid), 32'h1);
    chk("resume_rsp2_d", 32'(rsp_data), 32'hE0);
    drive(1'b1, 4'h0, 32'h0);
    @(negedge clk) chk("resume_rsp3_v", 32'(rsp_valid), 0);

    // Reset with three samples in flight.
    for (int s = 0; s < 3; s++) drive(1'b1, 4'hF, 32'h44332211);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 0);
    chk("midrst_act_valid", 32'(act_valid), 0);
    chk("midrst_act_data", 32'(act_data), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rsp_data", 32'(rsp_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_err", 32'(err), 0);
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      drive(1'b1, 4'h0, 32'h0);
      @(negedge clk);
      chk("postrst_rsp_valid", 32'(rsp_valid), 0);
      chk("postrst_err", 32'(err), 0);
    end

    // Latency mismatch: unit stub now takes 2 cycles.
    sel2 = 1'b1;
    drive(1'b1, 4'h4, 32'h00770000);
    @(negedge clk) chk("mis_ready", 32'(req_ready), 32'h4);
    drive(1'b1, 4'h0, 32'h0);
    @(negedge clk) chk("mis_err_t1", 32'(err), 0);
    drive(1'b1, 4'h0, 32'h0);
    @(negedge clk) chk("mis_err_t2", 32'(err), 0);
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 4'h0, 32'h0);
      @(negedge clk);
      chk("mis_err_sticky", 32'(err), 1);
      chk("mis_rsp_valid", 32'(rsp_valid), 0);
    end
    rst_n = 1'b0;
    #1 chk("mis_err_cleared", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
